matrix_scan_driver: RTL

MATRIX_SCAN_DRIVER -- requirements
Module: matrix_scan_driver

---
 rtl/matrix_scan_driver_pkg.sv | 28 ++
 rtl/matrix_scan_counter.sv | 65 ++++++
 rtl/matrix_scan_driver.sv | 113 +++++++++++
 3 files changed

// File: rtl/matrix_scan_driver_pkg.sv
// Shared geometry, code mapping and FSM state type for the 7x5 matrix scan driver.
package matrix_scan_driver_pkg;

    localparam int ROWS        = 7;
    localparam int COLS        = 5;
    localparam int CELLS       = ROWS * COLS;
    localparam int CODE_OFFSET = 1;
    localparam int ROW_W       = 3;
    localparam int COL_W       = 3;
    localparam int DWELL_W     = 8;
    localparam int IDX_W       = 6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

    function automatic logic [IDX_W-1:0] cell_index(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        return IDX_W'(row * COLS) + IDX_W'(col);
    endfunction

    // Offset keeps code 0 free to mean "no cell selected".
    function automatic logic [2:0] to_code(input logic [2:0] value);
        return value + 3'(CODE_OFFSET);
    endfunction

endpackage

// File: rtl/matrix_scan_counter.sv
// Row-major row/col/dwell counter chain; wrap marks the last dwell cycle of the last cell.
module matrix_scan_counter
    import matrix_scan_driver_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               advance,
    output logic [ROW_W-1:0]   row,
    output logic [COL_W-1:0]   col,
    output logic [DWELL_W-1:0] dwell,
    output logic               wrap
);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);

    logic [ROW_W-1:0]   row_reg, row_next;
    logic [COL_W-1:0]   col_reg, col_next;
    logic [DWELL_W-1:0] dwell_reg, dwell_next;

    always_comb begin
        row_next   = row_reg;
        col_next   = col_reg;
        dwell_next = dwell_reg;
        if (clear) begin
            row_next   = '0;
            col_next   = '0;
            dwell_next = '0;
        end else if (advance) begin
            if (dwell_reg == DWELL_LAST) begin
                dwell_next = '0;
                if (col_reg == COL_LAST) begin
                    col_next = '0;
                    row_next = (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
                end else begin
                    col_next = col_reg + 1'b1;
                end
            end else begin
                dwell_next = dwell_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_reg   <= '0;
            col_reg   <= '0;
            dwell_reg <= '0;
        end else begin
            row_reg   <= row_next;
            col_reg   <= col_next;
            dwell_reg <= dwell_next;
        end
    end

    assign row   = row_reg;
    assign col   = col_reg;
    assign dwell = dwell_reg;
    assign wrap  = (row_reg == ROW_LAST) && (col_reg == COL_LAST) && (dwell_reg == DWELL_LAST);

endmodule

// File: rtl/matrix_scan_driver.sv
// 7x5 LED matrix scan driver: double-buffered frame with tear-free swap at the frame boundary.
module matrix_scan_driver
    import matrix_scan_driver_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CELLS-1:0] frame,
    output logic             ready,
    output logic             ipt,
    output logic             sel0,
    output logic             sel1,
    output logic             sel2,
    output logic             sel3,
    output logic             sel4,
    output logic             sel5,
    output logic             frame_done
);

    scan_state_e        state_reg, state_next;
    logic               counter_clear, counter_advance;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic [DWELL_W-1:0] dwell;
    logic               wrap;

    logic [CELLS-1:0]   active_reg, active_next;
    logic [CELLS-1:0]   pending_reg, pending_next;
    logic               pending_valid_reg, pending_valid_next;
    logic               load_accept;
    logic               scan_active;
    logic [2:0]         col_code, row_code;

    matrix_scan_counter #(.DWELL(DWELL)) u_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (counter_clear),
        .advance (counter_advance),
        .row     (row),
        .col     (col),
        .dwell   (dwell),
        .wrap    (wrap)
    );

    always_comb begin
        state_next      = state_reg;
        counter_clear   = 1'b0;
        counter_advance = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                counter_clear = 1'b1;
                if (en) state_next = ST_SCAN;
            end
            ST_SCAN: begin
                if (!en) begin
                    state_next    = ST_IDLE;
                    counter_clear = 1'b1;
                end else begin
                    counter_advance = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // An accepted load implies the pending slot was empty, so it never collides with a swap.
    always_comb begin
        active_next        = active_reg;
        pending_next       = pending_reg;
        pending_valid_next = pending_valid_reg;
        load_accept        = load && !pending_valid_reg;
        if (state_reg == ST_IDLE) begin
            if (load_accept) active_next = frame;
        end else begin
            if (wrap && pending_valid_reg) begin
                active_next        = pending_reg;
                pending_valid_next = 1'b0;
            end
            if (load_accept) begin
                pending_next       = frame;
                pending_valid_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            active_reg        <= '0;
            pending_reg       <= '0;
            pending_valid_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            active_reg        <= active_next;
            pending_reg       <= pending_next;
            pending_valid_reg <= pending_valid_next;
        end
    end

    // Outputs decode registered state only; dwell 0 is the blank anti-ghost cycle.
    assign scan_active = (state_reg == ST_SCAN);
    assign col_code    = scan_active ? to_code(col) : 3'b000;
    assign row_code    = scan_active ? to_code(row) : 3'b000;
    assign {sel0, sel1, sel2} = col_code;
    assign {sel3, sel4, sel5} = row_code;
    assign ipt         = scan_active && (dwell != '0) && active_reg[cell_index(row, col)];
    assign frame_done  = scan_active && wrap;
    assign ready       = !pending_valid_reg;

endmodule
